// File: rtl/car_pkg.sv
// Shared car definitions: FSM state encodings, odometer geometry and a BCD digit helper.
package car_pkg;

  typedef enum logic [3:0] {
    POWER_OFF    = 4'b0000,
    POWER_ON     = 4'b0001,
    NOT_STARTING = 4'b0010,
    STARTING     = 4'b0011,
    MOVING       = 4'b0100
  } carState_e;

  localparam int BCD_DIGITS = 8;
  localparam int BCD_WIDTH  = BCD_DIGITS * 4;

  // Adds carryIn to one BCD digit; returns {carryOut, digit}. Nine (or anything above) rolls to zero.
  function automatic logic [4:0] bcdDigitInc(input logic [3:0] digit, input logic carryIn);
    logic [4:0] result;
    result = {1'b0, digit};
    if (carryIn) begin
      if (digit >= 4'd9) begin
        result = 5'b1_0000;
      end else begin
        result = {1'b0, digit + 4'd1};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mileage_tracker_if.sv
// Bundle of FSM-side inputs and odometer/idle outputs of the mileage tracker.
interface mileage_tracker_if;
  import car_pkg::*;

  logic [3:0]           state;
  logic                 move_forward;
  logic                 move_backward;
  logic                 user_activity;
  logic                 clear_mileage;
  logic [BCD_WIDTH-1:0] mileage_bcd;
  logic                 mileage_overflow;
  logic                 unit_tick;
  logic                 auto_power_off;

  modport master (
    output state, move_forward, move_backward, user_activity, clear_mileage,
    input  mileage_bcd, mileage_overflow, unit_tick, auto_power_off
  );

  modport slave (
    input  state, move_forward, move_backward, user_activity, clear_mileage,
    output mileage_bcd, mileage_overflow, unit_tick, auto_power_off
  );

endinterface

// File: rtl/mileage_tracker_bcd_counter8.sv
// Eight-digit packed BCD register with ripple-carry increment and synchronous clear.
module bcd_counter8
  import car_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [BCD_WIDTH-1:0] value,
  output logic                 wrap
);

  logic [BCD_WIDTH-1:0] value_q;
  logic [BCD_WIDTH-1:0] value_d;
  logic [BCD_WIDTH-1:0] incremented;
  logic                 carry;

  // Ripple the increment through the digits; the carry out of the top digit means 99999999 -> 0.
  always_comb begin
    incremented = value_q;
    carry       = inc;
    wrap        = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      {carry, incremented[i*4 +: 4]} = bcdDigitInc(value_q[i*4 +: 4], carry);
    end
    wrap = carry;
  end

  // Clear wins over increment.
  always_comb begin
    value_d = clr ? '0 : incremented;
  end

  // Odometer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/mileage_tracker.sv
// Odometer and idle auto-power-off timer driven by the car FSM state and drive commands.
module mileage_tracker
  import car_pkg::*;
#(
  parameter int TICK_CYCLES    = 100000000,
  parameter int SEC_CYCLES     = 100000000,
  parameter int IDLE_TIMEOUT_S = 10
) (
  input  logic             sys_clk,
  input  logic             rst,
  mileage_tracker_if.slave bus
);

  localparam int DIST_W = $clog2(TICK_CYCLES);
  localparam int SEC_W  = $clog2(SEC_CYCLES);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT_S + 1);

  localparam logic [DIST_W-1:0] DIST_LAST = DIST_W'(TICK_CYCLES - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT_S - 1);

  logic                 motion;
  logic                 clearing;
  logic                 idleActive;
  logic                 distWrap;
  logic                 secWrap;
  logic                 idleHit;
  logic                 tickInc;
  logic                 bcdWrap;
  logic [BCD_WIDTH-1:0] bcdValue;

  logic [DIST_W-1:0] distCount_q, distCount_d;
  logic [SEC_W-1:0]  secCount_q,  secCount_d;
  logic [IDLE_W-1:0] idleSec_q,   idleSec_d;
  logic              unitTick_q,  unitTick_d;
  logic              overflow_q,  overflow_d;
  logic              autoOff_q,   autoOff_d;

  // Decode what the car is doing this cycle; unknown state codes neither move nor idle.
  always_comb begin
    motion     = (bus.state == MOVING) && (bus.move_forward ^ bus.move_backward);
    clearing   = bus.clear_mileage || (bus.state == POWER_OFF);
    idleActive = ((bus.state == POWER_ON) || (bus.state == NOT_STARTING)) && !bus.user_activity;
    distWrap   = motion && (distCount_q == DIST_LAST);
    secWrap    = idleActive && (secCount_q == SEC_LAST);
    idleHit    = secWrap && (idleSec_q == IDLE_LAST);
    tickInc    = distWrap && !clearing;
  end

  // Distance prescaler: any gap in motion throws away the partial unit.
  always_comb begin
    distCount_d = distCount_q + DIST_W'(1);
    if (!motion || distWrap) begin
      distCount_d = '0;
    end
    unitTick_d = tickInc;
    overflow_d = clearing ? 1'b0 : (overflow_q || bcdWrap);
  end

  // Idle timer: seconds accumulate only while idle; the timeout pulses once and restarts timing.
  always_comb begin
    secCount_d = secCount_q + SEC_W'(1);
    idleSec_d  = idleSec_q;
    autoOff_d  = idleHit;
    if (!idleActive) begin
      secCount_d = '0;
      idleSec_d  = '0;
    end else if (secWrap) begin
      secCount_d = '0;
      idleSec_d  = idleHit ? '0 : idleSec_q + IDLE_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      distCount_q <= '0;
      secCount_q  <= '0;
      idleSec_q   <= '0;
      unitTick_q  <= 1'b0;
      overflow_q  <= 1'b0;
      autoOff_q   <= 1'b0;
    end else begin
      distCount_q <= distCount_d;
      secCount_q  <= secCount_d;
      idleSec_q   <= idleSec_d;
      unitTick_q  <= unitTick_d;
      overflow_q  <= overflow_d;
      autoOff_q   <= autoOff_d;
    end
  end

  bcd_counter8 uBcd (
    .clk   (sys_clk),
    .rst   (rst),
    .inc   (tickInc),
    .clr   (clearing),
    .value (bcdValue),
    .wrap  (bcdWrap)
  );

  assign bus.mileage_bcd      = bcdValue;
  assign bus.mileage_overflow = overflow_q;
  assign bus.unit_tick        = unitTick_q;
  assign bus.auto_power_off   = autoOff_q;

endmodule

// File: tb/tb_mileage_tracker.sv
// Directed bench for mileage_tracker with small prescalers (4 cycles per unit/second, 3 s timeout).
module tb_mileage_tracker;
  import car_pkg::*;

  logic sys_clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  mileage_tracker_if bus ();

  mileage_tracker #(
    .TICK_CYCLES    (4),
    .SEC_CYCLES     (4),
    .IDLE_TIMEOUT_S (3)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  // 100 MHz clock
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Drive all FSM-side inputs at once
  task automatic applyStimulus(input logic [3:0] st, input logic fwd, input logic bwd,
                               input logic act, input logic clr);
    bus.state         = st;
    bus.move_forward  = fwd;
    bus.move_backward = bwd;
    bus.user_activity = act;
    bus.clear_mileage = clr;
  endtask

  // Compare one observed value against its expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one
  task automatic stepCycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Drive n whole units of motion, then stop for one cycle
  task automatic runUnits(input int n, input logic backward);
    applyStimulus(MOVING, !backward, backward, 1'b0, 1'b0);
    stepCycles(4 * n);
    applyStimulus(MOVING, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycles(1);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    applyStimulus(POWER_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycles(2);
    checkOutput("rstMileage",  bus.mileage_bcd, 32'h0);
    checkOutput("rstOverflow", {31'b0, bus.mileage_overflow}, 32'd0);
    checkOutput("rstTick",     {31'b0, bus.unit_tick}, 32'd0);
    checkOutput("rstApo",      {31'b0, bus.auto_power_off}, 32'd0);
    rst = 1'b0;
    stepCycles(1);

    // Continuous forward motion: ticks after edges 4, 8, 12
    applyStimulus(MOVING, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      stepCycles(1);
      checkOutput("fwdTick", {31'b0, bus.unit_tick}, (k % 4 == 0) ? 32'd1 : 32'd0);
    end
    checkOutput("fwdMileage", bus.mileage_bcd, 32'h00000003);
    applyStimulus(MOVING, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycles(1);

    // Backward also adds distance; cross a decimal carry
    runUnits(96, 1'b1);
    checkOutput("bwdMileage99", bus.mileage_bcd, 32'h00000099);
    runUnits(1, 1'b0);
    checkOutput("carry100", bus.mileage_bcd, 32'h00000100);

    // Interrupted motion discards partial units
    applyStimulus(MOVING, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      stepCycles(1);
      checkOutput("gapTickA", {31'b0, bus.unit_tick}, 32'd0);
    end
    applyStimulus(MOVING, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycles(1);
    applyStimulus(MOVING, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      stepCycles(1);
      checkOutput("gapTickB", {31'b0, bus.unit_tick}, 32'd0);
    end
    applyStimulus(MOVING, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycles(1);

    // Both directions, a non-moving state and an unused code: no distance
    applyStimulus(MOVING, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      stepCycles(1);
      checkOutput("bothTick", {31'b0, bus.unit_tick}, 32'd0);
    end
    applyStimulus(STARTING, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      stepCycles(1);
      checkOutput("startingTick", {31'b0, bus.unit_tick}, 32'd0);
    end
    applyStimulus(4'b1100, 1'b1, 1'b0, 1'b0, 1'b0);
    stepCycles(8);
    checkOutput("heldMileage", bus.mileage_bcd, 32'h00000100);

    // Clear lands on the same edge as a scheduled increment
    applyStimulus(MOVING, 1'b1, 1'b0, 1'b0, 1'b0);
    stepCycles(3);
    applyStimulus(MOVING, 1'b1, 1'b0, 1'b0, 1'b1);
    stepCycles(1);
    checkOutput("clrTick",    {31'b0, bus.unit_tick}, 32'd0);
    checkOutput("clrMileage", bus.mileage_bcd, 32'h0);
    applyStimulus(MOVING, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycles(1);
    runUnits(1, 1'b0);
    checkOutput("afterClr", bus.mileage_bcd, 32'h00000001);

    // Full-scale wrap from a preloaded 99999999
    force dut.uBcd.value_q = 32'h99999999;
    #1;
    release dut.uBcd.value_q;
    runUnits(1, 1'b0);
    checkOutput("wrapMileage",  bus.mileage_bcd, 32'h0);
    checkOutput("wrapOverflow", {31'b0, bus.mileage_overflow}, 32'd1);
    runUnits(1, 1'b0);
    checkOutput("stickyMileage",  bus.mileage_bcd, 32'h00000001);
    checkOutput("stickyOverflow", {31'b0, bus.mileage_overflow}, 32'd1);
    applyStimulus(POWER_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycles(1);
    checkOutput("offMileage",  bus.mileage_bcd, 32'h0);
    checkOutput("offOverflow", {31'b0, bus.mileage_overflow}, 32'd0);

    // Idle timeout: pulse after 12 edges, then again 12 edges later
    applyStimulus(POWER_ON, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      stepCycles(1);
      checkOutput("idleApo", {31'b0, bus.auto_power_off}, (k == 12 || k == 24) ? 32'd1 : 32'd0);
    end

    // User activity restarts the idle timing
    applyStimulus(POWER_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycles(1);
    applyStimulus(NOT_STARTING, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      stepCycles(1);
      checkOutput("preActApo", {31'b0, bus.auto_power_off}, 32'd0);
    end
    applyStimulus(NOT_STARTING, 1'b0, 1'b0, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("actApo", {31'b0, bus.auto_power_off}, 32'd0);
    applyStimulus(NOT_STARTING, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      stepCycles(1);
      checkOutput("postActApo", {31'b0, bus.auto_power_off}, (k == 12) ? 32'd1 : 32'd0);
    end

    // Mid-operation reset suppresses an imminent pulse and zeroes the odometer
    applyStimulus(POWER_OFF, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycles(1);
    runUnits(42, 1'b0);
    checkOutput("mileage42", bus.mileage_bcd, 32'h00000042);
    applyStimulus(POWER_ON, 1'b0, 1'b0, 1'b0, 1'b0);
    stepCycles(11);
    checkOutput("preRstApo", {31'b0, bus.auto_power_off}, 32'd0);
    rst = 1'b1;
    stepCycles(1);
    checkOutput("midRstMileage",  bus.mileage_bcd, 32'h0);
    checkOutput("midRstApo",      {31'b0, bus.auto_power_off}, 32'd0);
    checkOutput("midRstTick",     {31'b0, bus.unit_tick}, 32'd0);
    checkOutput("midRstOverflow", {31'b0, bus.mileage_overflow}, 32'd0);
    rst = 1'b0;
    applyStimulus(MOVING, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      stepCycles(1);
      checkOutput("postRstTick", {31'b0, bus.unit_tick}, (k == 4) ? 32'd1 : 32'd0);
    end
    checkOutput("postRstMileage", bus.mileage_bcd, 32'h00000001);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
